// File: rtl/bind_change_monitor_if.sv
// Event-stream port of bind_change_monitor: the head record of the event FIFO
// together with its valid/ready handshake.
interface bind_change_monitor_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned TS_WIDTH = 16
);
    logic                      ev_valid;
    logic                      ev_ready;
    logic [TS_WIDTH-1:0]       ev_ts;
    logic [NUM_CH-1:0]         ev_mask;
    logic [NUM_CH*WIDTH-1:0]   ev_data;

    modport master (
        output ev_valid,
        output ev_ts,
        output ev_mask,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_ts,
        input  ev_mask,
        input  ev_data,
        output ev_ready
    );
endinterface

// File: rtl/bind_change_monitor.sv
// Multi-channel change monitor: time-stamps every change of mon_in and queues
// {ts, mask, sample} records in a first-word-fall-through FIFO.
module bind_change_monitor #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clr,
    input  logic [NUM_CH*WIDTH-1:0]       mon_in,
    bind_change_monitor_if.master         ev,
    output logic [NUM_CH*CNT_WIDTH-1:0]   trans_cnt,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic [$clog2(DEPTH):0]        fifo_level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        DISABLED,
        ARM,
        RUN
    } state_e;

    typedef struct packed {
        logic [TS_WIDTH-1:0]     ts;
        logic [NUM_CH-1:0]       mask;
        logic [NUM_CH*WIDTH-1:0] data;
    } rec_t;

    state_e                              state_q, state_d;
    logic [NUM_CH*WIDTH-1:0]             prev_q, prev_d;
    logic [TS_WIDTH-1:0]                 ts_q;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                                ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]                drop_q, drop_d;
    logic [LVL_W-1:0]                    level_q, level_d;
    logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
    rec_t                                mem_q [DEPTH];

    logic              compare;
    logic [NUM_CH-1:0] mask;
    logic              push, pop, full, wr_en, drop;
    rec_t              rec_in, rec_head;

    // State machine and baseline sample
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        compare = 1'b0;
        case (state_q)
            DISABLED: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                prev_d  = mon_in;
                state_d = RUN;
            end
            RUN: begin
                if (enable) begin
                    compare = 1'b1;
                    prev_d  = mon_in;
                end else begin
                    state_d = DISABLED;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mask[i] = compare && (mon_in[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
        end
    end

    // A push into a full FIFO survives only when the head leaves on the same edge
    assign push   = |mask;
    assign full   = (level_q == FULL_LVL);
    assign pop    = ev.ev_valid && ev.ev_ready;
    assign wr_en  = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign rec_in = '{ts: ts_q, mask: mask, data: mon_in};

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clr) begin
            cnt_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (mask[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DISABLED;
            prev_q   <= '0;
            ts_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            ts_q     <= ts_q + TS_WIDTH'(1);
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= rec_in;
    end

    // Storage is not reset, so head fields are forced to zero while empty
    assign rec_head    = mem_q[rd_ptr_q];
    assign ev.ev_valid = (level_q != '0);
    assign ev.ev_ts    = ev.ev_valid ? rec_head.ts   : '0;
    assign ev.ev_mask  = ev.ev_valid ? rec_head.mask : '0;
    assign ev.ev_data  = ev.ev_valid ? rec_head.data : '0;

    assign trans_cnt  = cnt_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;
endmodule
